// File: rtl/song_sequencer.sv
// song_sequencer: walks a song held in an external synchronous note ROM.
// It presents one note/duration pair per entry with a one-cycle load strobe,
// then waits for the player's done pulse before fetching the next entry.
// Pause, song changes, end markers and the last slot are handled here.
module song_sequencer #(
  parameter int IDX_BITS  = 5,
  parameter int SONG_BITS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play_enable,
  input  logic [SONG_BITS-1:0]          song,
  input  logic                          note_done,
  output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
  input  logic [11:0]                   rom_data,
  output logic [5:0]                    note_to_load,
  output logic [5:0]                    duration_to_load,
  output logic                          load_new_note,
  output logic                          song_done,
  output logic [IDX_BITS-1:0]           note_index
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    PLAYING = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [IDX_BITS-1:0] LAST_IDX = '1;

  state_t                state, state_n;
  logic [SONG_BITS-1:0]  song_q, song_n;
  logic [IDX_BITS-1:0]   idx_q, idx_n;
  logic [5:0]            note_n, dur_n;
  logic                  load_n, done_n;
  logic [5:0]            rom_note, rom_dur;
  logic                  song_changed;

  assign rom_note     = rom_data[11:6];
  assign rom_dur      = rom_data[5:0];
  assign song_changed = (song != song_q);

  // The ROM address comes straight from the registered song and index.
  assign rom_addr   = {song_q, idx_q};
  assign note_index = idx_q;

  // Register state, song/index and the output note/strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      song_q           <= '0;
      idx_q            <= '0;
      note_to_load     <= '0;
      duration_to_load <= '0;
      load_new_note    <= 1'b0;
      song_done        <= 1'b0;
    end else begin
      state            <= state_n;
      song_q           <= song_n;
      idx_q            <= idx_n;
      note_to_load     <= note_n;
      duration_to_load <= dur_n;
      load_new_note    <= load_n;
      song_done        <= done_n;
    end
  end

  // Next-state and next-output decode; a song change outranks every other event
  // once playback has started, and strobes default low every cycle.
  always_comb begin
    state_n = state;
    song_n  = song_q;
    idx_n   = idx_q;
    note_n  = note_to_load;
    dur_n   = duration_to_load;
    load_n  = 1'b0;
    done_n  = 1'b0;

    if (state == IDLE) begin
      if (play_enable) begin
        song_n  = song;
        idx_n   = '0;
        state_n = FETCH;
      end
    end else if (song_changed) begin
      // Restart at slot 0 of the new song; the old note keeps sounding.
      song_n  = song;
      idx_n   = '0;
      state_n = FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (play_enable) state_n = DECODE;
        end
        DECODE: begin
          if (!play_enable) begin
            // Re-read the ROM after the pause rather than trusting stale data.
            state_n = FETCH;
          end else if (rom_dur == 6'd0) begin
            done_n  = 1'b1;
            state_n = DONE;
          end else begin
            note_n  = rom_note;
            dur_n   = rom_dur;
            load_n  = 1'b1;
            state_n = PLAYING;
          end
        end
        PLAYING: begin
          if (note_done) begin
            if (idx_q == LAST_IDX) begin
              done_n  = 1'b1;
              idx_n   = '0;
              state_n = DONE;
            end else begin
              idx_n   = idx_q + IDX_BITS'(1);
              state_n = FETCH;
            end
          end
        end
        DONE: begin
          if (!play_enable) begin
            idx_n   = '0;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: directed stimulus pushes expected
// strobes (kind, note, duration, cycle) into a queue; a monitor pops and
// compares whenever the DUT raises load_new_note or song_done.
module tb_song_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        play_enable;
  logic [1:0]  song;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note_to_load;
  logic [5:0]  duration_to_load;
  logic        load_new_note;
  logic        song_done;
  logic [4:0]  note_index;

  song_sequencer #(.IDX_BITS(5), .SONG_BITS(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .play_enable      (play_enable),
    .song             (song),
    .note_done        (note_done),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .load_new_note    (load_new_note),
    .song_done        (song_done),
    .note_index       (note_index)
  );

  always #5 clk = ~clk;

  // Synchronous note ROM model
  logic [11:0] rom [0:127];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    int note;
    int dur;
    int at;
  } exp_t;
  exp_t exp_q[$];

  int applied = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int req);
    applied++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_load(input int n, input int d, input int at);
    exp_t e;
    e.is_done = 1'b0; e.note = n; e.dur = d; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int at);
    exp_t e;
    e.is_done = 1'b1; e.note = 0; e.dur = 0; e.at = at;
    exp_q.push_back(e);
  endtask

  function automatic int s2_note(input int i);
    return i + 1;
  endfunction

  function automatic int s2_dur(input int i);
    return (i % 5) + 1;
  endfunction

  // Monitor: every strobe must match the next expected event exactly.
  always @(negedge clk) begin
    if (load_new_note === 1'b1 || song_done === 1'b1) begin
      if (load_new_note === 1'b1 && song_done === 1'b1) begin
        applied++;
        miscompares++;
        $display("FAIL strobe_overlap: load and done both high at cycle %0d", cyc);
      end
      if (exp_q.size() == 0) begin
        applied++;
        miscompares++;
        $display("FAIL unexpected_strobe: load=%0b done=%0b at cycle %0d, none expected",
                 load_new_note, song_done, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("strobe_kind_is_done", int'(song_done), int'(e.is_done));
        chk("strobe_cycle", cyc, e.at);
        if (!e.is_done) begin
          chk("load_note", int'(note_to_load), e.note);
          chk("load_duration", int'(duration_to_load), e.dur);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_load"}, int'(load_new_note), 0);
    chk({tag, "_done"}, int'(song_done), 0);
    chk({tag, "_note"}, int'(note_to_load), 0);
    chk({tag, "_dur"}, int'(duration_to_load), 0);
    chk({tag, "_rom_addr"}, int'(rom_addr), 0);
    chk({tag, "_index"}, int'(note_index), 0);
  endtask

  initial begin
    int c;
    for (int a = 0; a < 128; a++) rom[a] = {6'd1, 6'd1};
    rom[7'h00] = {6'd11, 6'd2};
    rom[7'h20] = {6'd20, 6'd4};
    rom[7'h21] = {6'd0,  6'd3};   // rest
    rom[7'h22] = {6'd5,  6'd0};   // end marker
    for (int i = 0; i < 32; i++) rom[64 + i] = {6'(s2_note(i)), 6'(s2_dur(i))};
    rom[7'h60] = {6'd45, 6'd9};

    reset = 1'b1; play_enable = 1'b0; song = 2'd0; note_done = 1'b0;
    step(); step();
    check_all_zero("reset");
    reset = 1'b0;
    step();

    // Start song 1
    c = cyc;
    song = 2'd1; play_enable = 1'b1;
    push_load(20, 4, c + 3);
    step();
    chk("start_rom_addr", int'(rom_addr), 'h20);
    chk("start_index", int'(note_index), 0);
    step(); step(); step();
    chk("held_note", int'(note_to_load), 20);
    chk("held_dur", int'(duration_to_load), 4);

    // Advance to slot 1 (a rest)
    step();
    c = cyc;
    chk("adv_index_before", int'(note_index), 0);
    note_done = 1'b1;
    push_load(0, 3, c + 3);
    step();
    note_done = 1'b0;
    chk("adv_index", int'(note_index), 1);
    chk("adv_rom_addr", int'(rom_addr), 'h21);
    step(); step(); step();

    // End marker at slot 2
    c = cyc;
    note_done = 1'b1;
    push_done(c + 3);
    step();
    note_done = 1'b0;
    step(); step(); step(); step(); step();
    chk("done_hold_note", int'(note_to_load), 0);
    chk("done_hold_dur", int'(duration_to_load), 3);
    chk("done_hold_index", int'(note_index), 2);
    play_enable = 1'b0;
    step();
    chk("idle_index", int'(note_index), 0);
    step();

    // Pause during DECODE on song 3
    c = cyc;
    song = 2'd3; play_enable = 1'b1;
    push_load(45, 9, c + 9);
    step(); step();
    play_enable = 1'b0;
    repeat (5) step();
    chk("pause_rom_addr", int'(rom_addr), 'h60);
    play_enable = 1'b1;
    step(); step(); step();

    // Song change 3 -> 1 while playing
    c = cyc;
    song = 2'd1;
    push_load(20, 4, c + 3);
    step();
    chk("chg31_rom_addr", int'(rom_addr), 'h20);
    chk("chg31_index", int'(note_index), 0);
    step(); step(); step();

    // Song change 1 -> 2 in the same cycle as note_done
    c = cyc;
    song = 2'd2; note_done = 1'b1;
    push_load(s2_note(0), s2_dur(0), c + 3);
    step();
    note_done = 1'b0;
    chk("chg12_index", int'(note_index), 0);
    chk("chg12_rom_addr", int'(rom_addr), 'h40);
    step(); step(); step();

    // Full 32-slot song with no end marker
    for (int i = 0; i < 32; i++) begin
      c = cyc;
      chk("walk_index", int'(note_index), i);
      note_done = 1'b1;
      if (i < 31) push_load(s2_note(i + 1), s2_dur(i + 1), c + 3);
      else        push_done(c + 1);
      step();
      note_done = 1'b0;
      if (i < 31) begin
        step(); step(); step();
      end else begin
        chk("last_slot_index", int'(note_index), 0);
        chk("last_slot_rom_addr", int'(rom_addr), 'h40);
        step(); step();
      end
    end

    // Song change out of DONE to song 0
    c = cyc;
    song = 2'd0;
    push_load(11, 2, c + 3);
    step(); step(); step(); step();
    chk("song0_note", int'(note_to_load), 11);

    // Reset while PLAYING
    reset = 1'b1; play_enable = 1'b0;
    step();
    check_all_zero("reset_playing");
    reset = 1'b0;
    step();

    // Reset while DECODE has a load pending
    play_enable = 1'b1;
    step(); step();
    reset = 1'b1;
    step();
    chk("reset_decode_load", int'(load_new_note), 0);
    chk("reset_decode_note", int'(note_to_load), 0);
    reset = 1'b0; play_enable = 1'b0;
    step(); step(); step();

    applied++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_strobes: %0d expected strobes never seen, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
